// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared state and owner encodings for the two-requester arbiter
package arb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_t;

  // Owner values double as the external mux select: 0 steers A, 1 steers B.
  localparam logic OWN_A = 1'b0;
  localparam logic OWN_B = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// rtl/rr_pick2.sv - combinational round-robin pick between two level requests
import arb_pkg::*;

module rr_pick2 (
  input  logic ReqA,
  input  logic ReqB,
  input  logic Last,
  output logic Valid,
  output logic Owner
);

  assign Valid = ReqA | ReqB;
  // On a tie the requester that did not own the last grant wins.
  assign Owner = (ReqA & ReqB) ? ~Last : (ReqB ? OWN_B : OWN_A);

endmodule

// File: rtl/mux2_share_arbiter.sv
// rtl/mux2_share_arbiter.sv - round-robin time-share of one resource between A and B
import arb_pkg::*;

module mux2_share_arbiter #(
  parameter int LAT = 3,
  parameter int CW  = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic ReqA,
  input  logic ReqB,
  output logic Sel,
  output logic GntA,
  output logic GntB,
  output logic MemEn,
  output logic DoneA,
  output logic DoneB,
  output logic Busy
);

  localparam logic [CW-1:0] CNT_LOAD = CW'(LAT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  arb_state_t    r_state;
  logic [CW-1:0] r_cnt;
  logic          r_last;
  logic          r_sel;
  logic          r_gnt_a;
  logic          r_gnt_b;
  logic          r_mem_en;
  logic          r_done_a;
  logic          r_done_b;
  logic          r_busy;

  arb_state_t    w_state_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_last_nxt;
  logic          w_sel_nxt;
  logic          w_gnt_a_nxt;
  logic          w_gnt_b_nxt;
  logic          w_mem_en_nxt;
  logic          w_done_a_nxt;
  logic          w_done_b_nxt;
  logic          w_busy_nxt;
  logic          w_valid;
  logic          w_owner;

  rr_pick2 u_pick (
    .ReqA  (ReqA),
    .ReqB  (ReqB),
    .Last  (r_last),
    .Valid (w_valid),
    .Owner (w_owner)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_last_nxt   = r_last;
    w_sel_nxt    = r_sel;
    w_gnt_a_nxt  = r_gnt_a;
    w_gnt_b_nxt  = r_gnt_b;
    w_mem_en_nxt = r_mem_en;
    w_done_a_nxt = r_done_a;
    w_done_b_nxt = r_done_b;
    w_busy_nxt   = r_busy;
    case (r_state)
      ST_IDLE: begin
        if (w_valid) begin
          w_state_nxt  = ST_BUSY;
          w_cnt_nxt    = CNT_LOAD;
          w_sel_nxt    = w_owner;
          w_gnt_a_nxt  = (w_owner == OWN_A);
          w_gnt_b_nxt  = (w_owner == OWN_B);
          w_mem_en_nxt = 1'b1;
          w_busy_nxt   = 1'b1;
          // A one-cycle window finishes in the same cycle it starts.
          w_done_a_nxt = (LAT == 1) && (w_owner == OWN_A);
          w_done_b_nxt = (LAT == 1) && (w_owner == OWN_B);
        end
      end
      ST_BUSY: begin
        if (r_cnt != '0) begin
          w_cnt_nxt    = r_cnt - CNT_ONE;
          w_done_a_nxt = r_gnt_a && (r_cnt == CNT_ONE);
          w_done_b_nxt = r_gnt_b && (r_cnt == CNT_ONE);
        end else begin
          w_state_nxt  = ST_IDLE;
          w_last_nxt   = r_sel;
          w_gnt_a_nxt  = 1'b0;
          w_gnt_b_nxt  = 1'b0;
          w_mem_en_nxt = 1'b0;
          w_done_a_nxt = 1'b0;
          w_done_b_nxt = 1'b0;
          w_busy_nxt   = 1'b0;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_last   <= 1'b1;
      r_sel    <= OWN_A;
      r_gnt_a  <= 1'b0;
      r_gnt_b  <= 1'b0;
      r_mem_en <= 1'b0;
      r_done_a <= 1'b0;
      r_done_b <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_last   <= w_last_nxt;
      r_sel    <= w_sel_nxt;
      r_gnt_a  <= w_gnt_a_nxt;
      r_gnt_b  <= w_gnt_b_nxt;
      r_mem_en <= w_mem_en_nxt;
      r_done_a <= w_done_a_nxt;
      r_done_b <= w_done_b_nxt;
      r_busy   <= w_busy_nxt;
    end
  end

  assign Sel   = r_sel;
  assign GntA  = r_gnt_a;
  assign GntB  = r_gnt_b;
  assign MemEn = r_mem_en;
  assign DoneA = r_done_a;
  assign DoneB = r_done_b;
  assign Busy  = r_busy;

endmodule

// File: tb/tb_mux2_share_arbiter.sv
// tb/tb_mux2_share_arbiter.sv - scoreboard bench for mux2_share_arbiter at LAT=3 and LAT=1
module tb_mux2_share_arbiter;

  typedef struct packed {
    int   left;
    logic owner;
    logic last;
  } mdl_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ReqA = 1'b0;
  logic ReqB = 1'b0;

  logic sel3, gnt_a3, gnt_b3, mem_en3, done_a3, done_b3, busy3;
  logic sel1, gnt_a1, gnt_b1, mem_en1, done_a1, done_b1, busy1;

  int checks = 0;
  int failures = 0;

  logic [6:0] exp_q3[$];
  logic [6:0] exp_q1[$];
  mdl_t m3, m1;

  always #5 clk = ~clk;

  mux2_share_arbiter #(.LAT(3), .CW(4)) u_dut3 (
    .clk(clk), .rst(rst), .ReqA(ReqA), .ReqB(ReqB),
    .Sel(sel3), .GntA(gnt_a3), .GntB(gnt_b3), .MemEn(mem_en3),
    .DoneA(done_a3), .DoneB(done_b3), .Busy(busy3)
  );

  mux2_share_arbiter #(.LAT(1), .CW(2)) u_dut1 (
    .clk(clk), .rst(rst), .ReqA(ReqA), .ReqB(ReqB),
    .Sel(sel1), .GntA(gnt_a1), .GntB(gnt_b1), .MemEn(mem_en1),
    .DoneA(done_a1), .DoneB(done_b1), .Busy(busy1)
  );

  // Window-level model: 'left' counts cycles still owed to the current owner.
  task automatic mdl_step(input mdl_t mi, input logic r, input logic ra, input logic rb,
                          input int lat, output mdl_t mo, output logic [6:0] v);
    logic in_win;
    mo = mi;
    if (r) begin
      mo.left = 0;
      mo.owner = 1'b0;
      mo.last = 1'b1;
    end else if (mi.left > 1) begin
      mo.left = mi.left - 1;
    end else if (mi.left == 1) begin
      mo.left = 0;
      mo.last = mi.owner;
    end else if (ra || rb) begin
      mo.owner = (ra && rb) ? !mi.last : rb;
      mo.left = lat;
    end
    in_win = (mo.left > 0);
    v = {mo.owner, in_win && !mo.owner, in_win && mo.owner, in_win,
         in_win && (mo.left == 1) && !mo.owner, in_win && (mo.left == 1) && mo.owner, in_win};
  endtask

  initial begin
    m3 = '{left: 0, owner: 1'b0, last: 1'b1};
    m1 = '{left: 0, owner: 1'b0, last: 1'b1};
  end

  always @(posedge clk) begin
    logic [6:0] v;
    mdl_t nx;
    mdl_step(m3, rst, ReqA, ReqB, 3, nx, v);
    m3 = nx;
    exp_q3.push_back(v);
    mdl_step(m1, rst, ReqA, ReqB, 1, nx, v);
    m1 = nx;
    exp_q1.push_back(v);
  end

  always @(posedge clk) begin
    logic [6:0] e;
    logic [6:0] a;
    #2;
    checks++;
    a = {sel3, gnt_a3, gnt_b3, mem_en3, done_a3, done_b3, busy3};
    if (exp_q3.size() == 0) begin
      failures++;
      $display("FAIL lat3_outputs t=%0t no expected entry, actual=%b", $time, a);
    end else begin
      e = exp_q3.pop_front();
      if (a !== e) begin
        failures++;
        $display("FAIL lat3_outputs t=%0t actual=%b required=%b (Sel GntA GntB MemEn DoneA DoneB Busy)", $time, a, e);
      end
    end
    checks++;
    a = {sel1, gnt_a1, gnt_b1, mem_en1, done_a1, done_b1, busy1};
    if (exp_q1.size() == 0) begin
      failures++;
      $display("FAIL lat1_outputs t=%0t no expected entry, actual=%b", $time, a);
    end else begin
      e = exp_q1.pop_front();
      if (a !== e) begin
        failures++;
        $display("FAIL lat1_outputs t=%0t actual=%b required=%b (Sel GntA GntB MemEn DoneA DoneB Busy)", $time, a, e);
      end
    end
  end

  task automatic apply(input logic r, input logic a, input logic b, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #4;
      rst = r;
      ReqA = a;
      ReqB = b;
      if (r) begin
        #1;
        checks++;
        if ({sel3, gnt_a3, gnt_b3, mem_en3, done_a3, done_b3, busy3,
             sel1, gnt_a1, gnt_b1, mem_en1, done_a1, done_b1, busy1} !== 14'b0) begin
          failures++;
          $display("FAIL async_reset t=%0t actual=%b%b required=all zero", $time,
                   {sel3, gnt_a3, gnt_b3, mem_en3, done_a3, done_b3, busy3},
                   {sel1, gnt_a1, gnt_b1, mem_en1, done_a1, done_b1, busy1});
        end
      end
    end
  endtask

  initial begin
    apply(1'b1, 1'b0, 1'b0, 2);
    apply(1'b0, 1'b0, 1'b0, 1);
    apply(1'b0, 1'b1, 1'b0, 1);
    apply(1'b0, 1'b0, 1'b0, 6);
    apply(1'b0, 1'b1, 1'b1, 17);
    apply(1'b0, 1'b0, 1'b0, 3);
    apply(1'b0, 1'b1, 1'b0, 2);
    apply(1'b0, 1'b1, 1'b1, 1);
    apply(1'b0, 1'b0, 1'b1, 6);
    apply(1'b0, 1'b1, 1'b0, 2);
    apply(1'b0, 1'b0, 1'b0, 5);
    apply(1'b0, 1'b0, 1'b1, 2);
    apply(1'b1, 1'b0, 1'b1, 1);
    apply(1'b0, 1'b1, 1'b1, 10);
    apply(1'b0, 1'b0, 1'b1, 8);
    for (int i = 0; i < 3000; i++) begin
      logic ra, rb, rr;
      ra = ($urandom_range(0, 3) != 0) ? ReqA : logic'($urandom_range(0, 1));
      rb = ($urandom_range(0, 3) != 0) ? ReqB : logic'($urandom_range(0, 1));
      rr = ($urandom_range(0, 99) == 0);
      apply(rr, ra, rb, 1);
    end
    apply(1'b0, 1'b0, 1'b0, 6);
    @(posedge clk);
    #3;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
